cache_controller: RTL
=====================

Name: cache_controller

Overview:
Set-associative cache controller that owns and drives the cache_memory storage array. It accepts single-word CPU load/store requests and performs tag lookup through the array's hits/valid_flags. On a read miss it fills the line from main memory. It is write-through with no write-allocate, and uses per-set round-robin replacement. It sits between the core's data-memory port and the main-memory interface.

Parameters:
ADDR_SIZE, 32, address width
NUM_SETS, 16, sets in the array (power of 2)
NUM_WAYS, 4, ways per set (power of 2, >=2)
BLOCK_SIZE, 32, line/data width in bits (one word per line)
Derived (identical to the array): ByteOffsetSize=$clog2(BLOCK_SIZE/4), SetSize=$clog2(NUM_SETS), WaySize=$clog2(NUM_WAYS), TagSize=ADDR_SIZE-SetSize-ByteOffsetSize

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  CPU request present
req_ready  out  1  controller can accept a request
req_write  in  1  1=store, 0=load
req_addr  in  ADDR_SIZE  request address
req_wdata  in  BLOCK_SIZE  store data
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  BLOCK_SIZE  load data, valid with resp_valid on loads
mem_req  out  1  main-memory request, held until mem_ready
mem_we  out  1  main-memory write
mem_addr  out  ADDR_SIZE  main-memory address (latched req_addr)
mem_wdata  out  BLOCK_SIZE  main-memory write data
mem_ready  in  1  main memory completes the request this cycle
mem_rdata  in  BLOCK_SIZE  read data, valid with mem_ready
cache_way  out  WaySize  array way select
cache_set  out  SetSize  array set select
cache_tag  out  TagSize  array tag
cache_we  out  1  array write enable
cache_wdata  out  BLOCK_SIZE  array write data
cache_rdata  in  BLOCK_SIZE  array read data (combinational from way/set)
cache_hits  in  NUM_WAYS  per-way hit flags for cache_set/cache_tag
cache_valid  in  NUM_WAYS  per-way valid flags for cache_set
hit_count  out  32  loads+stores that hit
miss_count  out  32  loads+stores that missed

Behaviour:
- Address split of the latched address: set = addr[ByteOffsetSize +: SetSize]; tag = addr[ADDR_SIZE-1 -: TagSize]. cache_set and cache_tag are always driven from the latched address.
- FSM states: IDLE, LOOKUP, MEM_READ, MEM_WRITE. req_ready = (state==IDLE).
- IDLE: when req_valid is high, latch addr, wdata and write, then go to LOOKUP.
- LOOKUP (one cycle):
  - Hit way = lowest-index set bit of cache_hits; cache_way = hit way.
  - Load hit: resp_valid=1 and resp_rdata=cache_rdata this cycle; go to IDLE. Latency is 1 cycle after acceptance.
  - Store hit: cache_we=1 and cache_wdata=latched wdata to the hit way; go to MEM_WRITE.
  - Load miss: go to MEM_READ. Store miss: go to MEM_WRITE with no allocate and no array write.
  - hit_count or miss_count increments by 1. Both counters wrap at 2^32.
- MEM_READ: mem_req=1, mem_we=0, mem_addr=latched addr, held until mem_ready.
  - In the mem_ready cycle: cache_we=1, cache_way=victim, cache_wdata=mem_rdata, resp_valid=1, resp_rdata=mem_rdata; go to IDLE.
- MEM_WRITE: mem_req=1, mem_we=1, mem_wdata=latched wdata, held until mem_ready. In the mem_ready cycle: resp_valid=1; go to IDLE.
- Victim selection (computed in MEM_READ):
  - Use the lowest-index way whose cache_valid bit is 0.
  - If all ways are valid, use rr_ptr[set], and rr_ptr[set] increments mod NUM_WAYS (wraps NUM_WAYS-1 -> 0) in the fill cycle.
  - rr_ptr is unchanged when an invalid way is used.
- cache_way outside LOOKUP and the fill cycle is 0. cache_we is 0 in every state except the two cases above.
- mem_req, mem_addr and mem_we stay stable while mem_req=1 && !mem_ready.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, mem_req=0, mem_we=0, cache_we=0, all rr_ptr=0, hit_count=0, miss_count=0.
- Reset mid-operation aborts any pending memory access: mem_req=0 from the first cycle after the reset edge, and no response is issued.
- mem_ready outside MEM_READ/MEM_WRITE is ignored.
- req_valid while busy is ignored (req_ready=0). A new request can be accepted in the cycle after resp_valid.

Test Plan:
- Reset then load 0x0000_0040 (array empty) -> miss. mem_req=1 with mem_we=0 and mem_addr=0x40. With mem_ready after 3 cycles and mem_rdata=0xDEADBEEF: cache_we to way 0; resp_rdata=0xDEADBEEF; miss_count=1.
- Repeat load 0x40 -> resp_valid 1 cycle after acceptance, resp_rdata=0xDEADBEEF, no mem_req, hit_count=1.
- Store 0x40 with data 0x12345678 (hit) -> cache_we to way 0 in LOOKUP. Then mem_req=1 with mem_we=1 and mem_wdata=0x12345678. resp on mem_ready. A following load of 0x40 hits and returns 0x12345678.
- Store to an uncached address -> no cache_we, memory write only, miss_count increments, and a following load of the same address misses.
- Five loads to distinct tags in set 0 -> the first four fill ways 0,1,2,3. The fifth evicts way 0 (rr_ptr 0->1). A sixth new tag evicts way 1.
- Assert rst during MEM_READ with mem_ready held low -> next cycle mem_req=0, req_ready=1, counters=0, and no resp_valid is ever produced for the aborted request.

Source files
------------

// File: rtl/cache_controller_if.sv
// CPU request/response, main-memory and cache-array control signals of cache_controller.
// master is the controller side; slave is the surrounding CPU, memory and array.
interface cache_controller_if #(
    parameter int ADDR_SIZE  = 32,
    parameter int NUM_SETS   = 16,
    parameter int NUM_WAYS   = 4,
    parameter int BLOCK_SIZE = 32
);
    localparam int ByteOffsetSize = $clog2(BLOCK_SIZE / 4);
    localparam int SetSize        = $clog2(NUM_SETS);
    localparam int WaySize        = $clog2(NUM_WAYS);
    localparam int TagSize        = ADDR_SIZE - SetSize - ByteOffsetSize;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_SIZE-1:0]  req_addr;
    logic [BLOCK_SIZE-1:0] req_wdata;
    logic                  resp_valid;
    logic [BLOCK_SIZE-1:0] resp_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_SIZE-1:0]  mem_addr;
    logic [BLOCK_SIZE-1:0] mem_wdata;
    logic                  mem_ready;
    logic [BLOCK_SIZE-1:0] mem_rdata;

    logic [WaySize-1:0]    cache_way;
    logic [SetSize-1:0]    cache_set;
    logic [TagSize-1:0]    cache_tag;
    logic                  cache_we;
    logic [BLOCK_SIZE-1:0] cache_wdata;
    logic [BLOCK_SIZE-1:0] cache_rdata;
    logic [NUM_WAYS-1:0]   cache_hits;
    logic [NUM_WAYS-1:0]   cache_valid;

    logic [31:0]           hit_count;
    logic [31:0]           miss_count;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
               mem_ready, mem_rdata, cache_rdata, cache_hits, cache_valid,
        output req_ready, resp_valid, resp_rdata,
               mem_req, mem_we, mem_addr, mem_wdata,
               cache_way, cache_set, cache_tag, cache_we, cache_wdata,
               hit_count, miss_count
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
               mem_ready, mem_rdata, cache_rdata, cache_hits, cache_valid,
        input  req_ready, resp_valid, resp_rdata,
               mem_req, mem_we, mem_addr, mem_wdata,
               cache_way, cache_set, cache_tag, cache_we, cache_wdata,
               hit_count, miss_count
    );
endinterface

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate set-associative cache controller; load hit responds 1 cycle after accept.
// Backpressure: one request in flight, req_ready only in IDLE; memory requests held until mem_ready.
module cache_controller #(
    parameter int ADDR_SIZE  = 32,
    parameter int NUM_SETS   = 16,
    parameter int NUM_WAYS   = 4,
    parameter int BLOCK_SIZE = 32
) (
    input logic               clk,
    input logic               rst,
    cache_controller_if.master bus
);
    localparam int ByteOffsetSize = $clog2(BLOCK_SIZE / 4);
    localparam int SetSize        = $clog2(NUM_SETS);
    localparam int WaySize        = $clog2(NUM_WAYS);
    localparam int TagSize        = ADDR_SIZE - SetSize - ByteOffsetSize;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOOKUP    = 2'd1;
    localparam logic [1:0] MEM_READ  = 2'd2;
    localparam logic [1:0] MEM_WRITE = 2'd3;

    logic [1:0]            state;
    logic [ADDR_SIZE-1:0]  addr_q;
    logic [BLOCK_SIZE-1:0] wdata_q;
    logic                  write_q;
    logic [WaySize-1:0]    rr_ptr [NUM_SETS];
    logic [31:0]           hit_count_q;
    logic [31:0]           miss_count_q;

    logic [SetSize-1:0]    set_idx;
    logic                  hit;
    logic                  all_valid;
    logic [WaySize-1:0]    hit_way;
    logic [WaySize-1:0]    victim_way;

    assign set_idx       = addr_q[ByteOffsetSize +: SetSize];
    assign bus.cache_set = set_idx;
    assign bus.cache_tag = addr_q[ADDR_SIZE-1 -: TagSize];
    assign hit           = |bus.cache_hits;
    assign all_valid     = &bus.cache_valid;

    assign bus.req_ready  = (state == IDLE);
    assign bus.mem_req    = (state == MEM_READ) || (state == MEM_WRITE);
    assign bus.mem_we     = (state == MEM_WRITE);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.hit_count  = hit_count_q;
    assign bus.miss_count = miss_count_q;

    // Descending scan so the lowest-index match wins.
    always_comb begin
        hit_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (bus.cache_hits[i]) hit_way = WaySize'(i);
        end
    end

    // Prefer any empty way; round-robin only once the set is full.
    always_comb begin
        victim_way = rr_ptr[set_idx];
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!bus.cache_valid[i]) victim_way = WaySize'(i);
        end
    end

    always_comb begin
        bus.resp_valid  = 1'b0;
        bus.resp_rdata  = '0;
        bus.cache_way   = '0;
        bus.cache_we    = 1'b0;
        bus.cache_wdata = '0;
        case (state)
            LOOKUP: begin
                bus.cache_way = hit_way;
                if (hit && !write_q) begin
                    bus.resp_valid = 1'b1;
                    bus.resp_rdata = bus.cache_rdata;
                end
                if (hit && write_q) begin
                    bus.cache_we    = 1'b1;
                    bus.cache_wdata = wdata_q;
                end
            end
            MEM_READ: begin
                if (bus.mem_ready) begin
                    bus.cache_we    = 1'b1;
                    bus.cache_way   = victim_way;
                    bus.cache_wdata = bus.mem_rdata;
                    bus.resp_valid  = 1'b1;
                    bus.resp_rdata  = bus.mem_rdata;
                end
            end
            MEM_WRITE: begin
                if (bus.mem_ready) bus.resp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) rr_ptr[s] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        write_q <= bus.req_write;
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) hit_count_q  <= hit_count_q + 32'd1;
                    else     miss_count_q <= miss_count_q + 32'd1;
                    // Every store goes to memory; only load misses fill.
                    if (write_q)  state <= MEM_WRITE;
                    else if (hit) state <= IDLE;
                    else          state <= MEM_READ;
                end
                MEM_READ: begin
                    if (bus.mem_ready) begin
                        state <= IDLE;
                        if (all_valid) rr_ptr[set_idx] <= rr_ptr[set_idx] + WaySize'(1);
                    end
                end
                MEM_WRITE: begin
                    if (bus.mem_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
